ex_div: RTL and testbench

Multi-cycle 32-bit integer divider instantiated inside the execute stage. It consumes the `reg1`/`reg2` operands that the OF/EX pipeline register delivers for DIV/DIVU in issue slot 1. It produces `{HI, LO} = {remainder, quotient}` after a fixed iteration count. The execute stage holds the front end stalled until `ready_o` is seen.

---
 rtl/ex_div_pkg.sv | 32 +++
 rtl/ex_div_if.sv | 29 ++
 rtl/ex_div_step.sv | 28 ++
 rtl/ex_div.sv | 127 ++++++++++++
 tb/tb_ex_div.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ex_div_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_div_pkg : shared widths, state encodings and flag values for ex_div
// Revision   : 1.0
// ----------------------------------------------------------------------------
package ex_div_pkg;

  localparam int REG_BUS_W        = 32;
  localparam int DOUBLE_REG_BUS_W = 64;
  localparam int CNT_W            = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = 6'd32;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself.
  function automatic logic [REG_BUS_W-1:0] abs_if(input logic [REG_BUS_W-1:0] v,
                                                  input logic en);
    return (en && v[REG_BUS_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_div_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_div_if : request/result bundle between the execute stage and ex_div
// Revision  : 1.0
// ----------------------------------------------------------------------------
interface ex_div_if;
  import ex_div_pkg::*;

  logic                        signed_div_i;
  logic [REG_BUS_W-1:0]        opdata1_i;
  logic [REG_BUS_W-1:0]        opdata2_i;
  logic                        start_i;
  logic                        annul_i;
  logic [DOUBLE_REG_BUS_W-1:0] result_o;
  logic                        ready_o;
  logic                        busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/ex_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_div_step : one restoring-division iteration (trial subtract + shift)
// Revision    : 1.0
// ----------------------------------------------------------------------------
module ex_div_step
  import ex_div_pkg::*;
(
  input  logic [REG_BUS_W-2:0] rem_in,
  input  logic [REG_BUS_W-1:0] dividend_in,
  input  logic [REG_BUS_W-1:0] divisor,
  output logic [REG_BUS_W-1:0] rem_out,
  output logic [REG_BUS_W-1:0] quo_out
);

  logic [REG_BUS_W-1:0] shifted;
  logic [REG_BUS_W:0]   trial;

  // partial_rem < 2^k before step k+1, so dropping its MSB never loses data.
  always_comb begin
    shifted = {rem_in, dividend_in[REG_BUS_W-1]};
    trial   = {1'b0, shifted} - {1'b0, divisor};
    rem_out = trial[REG_BUS_W] ? shifted : trial[REG_BUS_W-1:0];
    quo_out = {dividend_in[REG_BUS_W-2:0], ~trial[REG_BUS_W]};
  end

endmodule
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_div : multi-cycle 32-bit signed/unsigned divider, {HI,LO} = {rem,quo}
// Revision : 1.0
// ----------------------------------------------------------------------------
module ex_div
  import ex_div_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  ex_div_if.slave div
);

  div_state_e                  state, state_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic [DOUBLE_REG_BUS_W-1:0] work, work_n;
  logic [REG_BUS_W-1:0]        divisor, divisor_n;
  logic                        sign_div, sign_div_n;
  logic                        dvd_neg, dvd_neg_n;
  logic                        dvs_neg, dvs_neg_n;
  logic [DOUBLE_REG_BUS_W-1:0] result, result_n;
  logic                        ready, ready_n;

  logic [REG_BUS_W-1:0] step_rem, step_quo;
  logic [REG_BUS_W-1:0] quo_fix, rem_fix;

  ex_div_step u_step (
    .rem_in      (work[DOUBLE_REG_BUS_W-2:REG_BUS_W]),
    .dividend_in (work[REG_BUS_W-1:0]),
    .divisor     (divisor),
    .rem_out     (step_rem),
    .quo_out     (step_quo)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sign_div <= 1'b0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
      result   <= '0;
      ready    <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      sign_div <= sign_div_n;
      dvd_neg  <= dvd_neg_n;
      dvs_neg  <= dvs_neg_n;
      result   <= result_n;
      ready    <= ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    work_n     = work;
    divisor_n  = divisor;
    sign_div_n = sign_div;
    dvd_neg_n  = dvd_neg;
    dvs_neg_n  = dvs_neg;
    result_n   = result;
    ready_n    = ready;

    quo_fix = (sign_div && (dvd_neg ^ dvs_neg)) ? (~work[REG_BUS_W-1:0] + 1'b1)
                                                : work[REG_BUS_W-1:0];
    rem_fix = (sign_div && dvd_neg) ? (~work[DOUBLE_REG_BUS_W-1:REG_BUS_W] + 1'b1)
                                    : work[DOUBLE_REG_BUS_W-1:REG_BUS_W];

    if (div.annul_i) begin
      state_n  = DIV_FREE;
      cnt_n    = '0;
      result_n = '0;
      ready_n  = DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
          if (div.start_i == DIV_START) begin
            sign_div_n = div.signed_div_i;
            dvd_neg_n  = div.opdata1_i[REG_BUS_W-1];
            dvs_neg_n  = div.opdata2_i[REG_BUS_W-1];
            work_n     = {{REG_BUS_W{1'b0}}, abs_if(div.opdata1_i, div.signed_div_i)};
            divisor_n  = abs_if(div.opdata2_i, div.signed_div_i);
            cnt_n      = '0;
            state_n    = (div.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          result_n = '0;
          ready_n  = DIV_RESULT_READY;
          state_n  = DIV_END;
        end
        DIV_ON: begin
          if (cnt == LAST_ITER) begin
            result_n = {rem_fix, quo_fix};
            ready_n  = DIV_RESULT_READY;
            state_n  = DIV_END;
          end else begin
            work_n = {step_rem, step_quo};
            cnt_n  = cnt + 1'b1;
          end
        end
        DIV_END: begin
          if (div.start_i == DIV_STOP) begin
            result_n = '0;
            ready_n  = DIV_RESULT_NOT_READY;
            state_n  = DIV_FREE;
          end
        end
        default: state_n = DIV_FREE;
      endcase
    end
  end

  assign div.result_o = result;
  assign div.ready_o  = ready;
  assign div.busy_o   = (state != DIV_FREE);

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ex_div : directed and randomized checks of ex_div against a / and % model
// Revision  : 1.0
// ----------------------------------------------------------------------------
module tb_ex_div;

  logic clk;
  logic resetn;
  int   n_assert;
  int   n_fail;

  ex_div_if dif ();

  ex_div dut (
    .clk    (clk),
    .resetn (resetn),
    .div    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference quotient/remainder from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic scramble);
    int   edges;
    logic quiet_ok;
    @(negedge clk);
    dif.signed_div_i = sg;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    edges    = 0;
    quiet_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) chk("busy_after_start", 64'(dif.busy_o), 64'd1);
      if (!dif.ready_o && dif.result_o !== 64'd0) quiet_ok = 1'b0;
      if (scramble && edges == 5) begin
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = ~sg;
      end
    end while (!dif.ready_o && edges < 100);
    chk("latency", 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
    chk("result_zero_before_ready", 64'(quiet_ok), 64'd1);
    chk("result", dif.result_o, exp);
    repeat (2) @(posedge clk);
    #1;
    chk("ready_held", 64'(dif.ready_o), 64'd1);
    chk("result_held", dif.result_o, exp);
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_cleared", 64'(dif.ready_o), 64'd0);
    chk("result_cleared", dif.result_o, 64'd0);
    chk("busy_cleared", 64'(dif.busy_o), 64'd0);
  endtask

  initial begin
    logic        sg;
    logic [31:0] a, b;
    n_assert = 0;
    n_fail   = 0;
    resetn           = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(dif.ready_o), 64'd0);
    chk("reset_busy", 64'(dif.busy_o), 64'd0);
    chk("reset_result", dif.result_o, 64'd0);
    resetn = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 64'd0, 1'b0);

    // Annul at iteration 10, then restart on the very next cycle.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_busy", 64'(dif.busy_o), 64'd0);
    chk("annul_ready", 64'(dif.ready_o), 64'd0);
    chk("annul_result", dif.result_o, 64'd0);
    dif.annul_i = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b1);

    // Annul together with start in FREE: nothing starts.
    @(negedge clk);
    dif.opdata1_i = 32'd20;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_start_busy", 64'(dif.busy_o), 64'd0);
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;

    // Annul on the final (cnt == 32) edge.
    @(negedge clk);
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    dif.start_i   = 1'b1;
    repeat (33) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_last_ready", 64'(dif.ready_o), 64'd0);
    chk("annul_last_busy", 64'(dif.busy_o), 64'd0);
    chk("annul_last_result", dif.result_o, 64'd0);
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;

    // Reset at iteration 20, then a normal operation.
    @(negedge clk);
    dif.start_i = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_busy", 64'(dif.busy_o), 64'd0);
    chk("midreset_ready", 64'(dif.ready_o), 64'd0);
    chk("midreset_result", dif.result_o, 64'd0);
    resetn      = 1'b1;
    dif.start_i = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(sg, a, b, model(sg, a, b), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
